// File: rtl/pdp8_rf08.sv
// RF08 fixed-head disk controller: IOT decode, control registers and a three-cycle data-break engine.
// Optional extended disk address register (DCXA/DXAL/DXAC) enabled by defining RF_EMA_EN.
module pdp8_rf08 #(
  parameter int unsigned DiskAw = 12
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        iot_i,
  input  logic [3:0]  state_i,
  input  logic [11:0] mb_i,
  input  logic [5:0]  io_select_i,
  input  logic [11:0] io_data_i,
  output logic [11:0] io_data_o,
  output logic        io_data_avail_o,
  output logic        io_interrupt_o,
  output logic        io_skip_o,
  output logic        ram_read_req_o,
  output logic        ram_write_req_o,
  input  logic        ram_done_i,
  output logic [14:0] ram_ma_o,
  output logic [11:0] ram_out_o,
  input  logic [11:0] ram_in_i
);

  typedef enum logic [2:0] {StIdle, StWcr, StWcw, StCar, StCaw, StXfer} st_e;

  localparam logic [14:0] WcAddr = 15'o07750;
  localparam logic [14:0] CaAddr = 15'o07751;

  st_e         st_q;
  logic [11:0] dma_q, wc_q, ca_q, out_q;
  logic [2:0]  fld_q;
  logic        cie_q, eie_q, dcf_q, err_q, busy_q, dir_q, irq_q;
  logic        rd_q, wr_q;
  logic [14:0] ma_q;
  logic [7:0]  ema;

  logic [11:0] disk_q [(1 << DiskAw)];

`ifdef RF_EMA_EN
  logic [7:0] ema_q;
  assign ema = ema_q;
`else
  assign ema = 8'd0;
`endif

  logic [DiskAw-1:0] daddr;
  assign daddr = DiskAw'({ema, dma_q});

  // Device code must agree with the instruction word for a valid IOT.
  logic       dev_ok, commit, phase_ok;
  logic [8:0] code;
  assign dev_ok   = iot_i && (mb_i[11:9] == 3'o6) && (io_select_i == mb_i[8:3]);
  assign code     = {io_select_i, mb_i[2:0]};
  assign commit   = dev_ok && (state_i == 4'd1);
  assign phase_ok = dev_ok && (state_i >= 4'd1) && (state_i <= 4'd3);

  always_comb begin
    io_skip_o       = 1'b0;
    io_data_avail_o = 1'b0;
    io_data_o       = '0;
    if (phase_ok) begin
      case (code)
        9'o612: io_skip_o = ~busy_q;
        9'o616: begin
          io_data_avail_o = 1'b1;
          // DCF sits above bit 11 in the 13-bit status layout; it is read via DFSC.
          io_data_o = {err_q, eie_q, cie_q, 3'b000, fld_q, busy_q, 2'b00};
        end
        9'o621: io_skip_o = ~err_q;
        9'o622: io_skip_o = dcf_q;
        9'o623: io_skip_o = dcf_q | err_q;
        9'o626: begin
          io_data_avail_o = 1'b1;
          io_data_o       = dma_q;
        end
`ifdef RF_EMA_EN
        9'o645: begin
          io_data_avail_o = 1'b1;
          io_data_o       = {4'b0000, ema_q};
        end
`endif
        default: ;
      endcase
    end
  end

  assign io_interrupt_o  = irq_q;
  assign ram_read_req_o  = rd_q;
  assign ram_write_req_o = wr_q;
  assign ram_ma_o        = ma_q;
  assign ram_out_o       = out_q;

  // Disk array is storage, not control state, so it is not reset.
  always_ff @(posedge clk_i) begin
    if ((st_q == StXfer) && rd_q && ram_done_i && dir_q) begin
      disk_q[daddr] <= ram_in_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= StIdle;
      dma_q  <= '0;
      wc_q   <= '0;
      ca_q   <= '0;
      out_q  <= '0;
      fld_q  <= '0;
      cie_q  <= 1'b0;
      eie_q  <= 1'b0;
      dcf_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      dir_q  <= 1'b0;
      irq_q  <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      ma_q   <= '0;
`ifdef RF_EMA_EN
      ema_q  <= '0;
`endif
    end else begin
      irq_q <= (cie_q & dcf_q) | (eie_q & err_q);

      if (st_q != StIdle) begin
        if (!rd_q && !wr_q) begin
          // Issue the access for the current state; the idle cycle before it is the gap.
          case (st_q)
            StWcr: begin
              rd_q <= 1'b1;
              ma_q <= WcAddr;
            end
            StWcw: begin
              wr_q  <= 1'b1;
              ma_q  <= WcAddr;
              out_q <= wc_q;
            end
            StCar: begin
              rd_q <= 1'b1;
              ma_q <= CaAddr;
            end
            StCaw: begin
              wr_q  <= 1'b1;
              ma_q  <= CaAddr;
              out_q <= ca_q;
            end
            StXfer: begin
              ma_q <= {fld_q, ca_q};
              if (dir_q) begin
                rd_q <= 1'b1;
              end else begin
                wr_q  <= 1'b1;
                out_q <= disk_q[daddr];
              end
            end
            default: ;
          endcase
        end else if (ram_done_i) begin
          rd_q <= 1'b0;
          wr_q <= 1'b0;
          case (st_q)
            StWcr: begin
              wc_q <= ram_in_i + 12'd1;
              st_q <= StWcw;
            end
            StWcw: st_q <= StCar;
            StCar: begin
              ca_q <= ram_in_i + 12'd1;
              st_q <= StCaw;
            end
            StCaw: st_q <= StXfer;
            StXfer: begin
`ifdef RF_EMA_EN
              {ema_q, dma_q} <= {ema_q, dma_q} + 20'd1;
`else
              dma_q <= dma_q + 12'd1;
`endif
              if (wc_q == 12'd0) begin
                st_q   <= StIdle;
                busy_q <= 1'b0;
                dcf_q  <= 1'b1;
              end else begin
                st_q <= StWcr;
              end
            end
            default: ;
          endcase
        end
      end

      // CPU writes come last so they override engine updates on the same edge.
      if (commit) begin
        case (code)
          9'o601: begin
            dma_q <= '0;
            dcf_q <= 1'b0;
            err_q <= 1'b0;
          end
          9'o603, 9'o605: begin
            if (busy_q) begin
              err_q <= 1'b1;
            end else begin
              dma_q  <= io_data_i;
              dir_q  <= code[2];
              busy_q <= 1'b1;
              dcf_q  <= 1'b0;
              st_q   <= StWcr;
              rd_q   <= 1'b0;
              wr_q   <= 1'b0;
            end
          end
          9'o611: begin
            cie_q <= 1'b0;
            eie_q <= 1'b0;
            fld_q <= '0;
          end
          9'o615: begin
            eie_q <= io_data_i[10];
            cie_q <= io_data_i[9];
            fld_q <= io_data_i[5:3];
          end
`ifdef RF_EMA_EN
          9'o641: ema_q <= '0;
          9'o643: ema_q <= io_data_i[7:0];
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pdp8_rf08.sv
// Directed self-checking bench for pdp8_rf08 with a behavioural 32K-word memory.
module tb_pdp8_rf08;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iot;
  logic [3:0]  state;
  logic [11:0] mb;
  logic [5:0]  io_select;
  logic [11:0] io_data_in;
  logic [11:0] io_data_out;
  logic        io_data_avail, io_interrupt, io_skip;
  logic        rd, wr, ram_done;
  logic [14:0] ram_ma;
  logic [11:0] ram_out, ram_in;

  int checks = 0;
  int errors = 0;

  logic [11:0] mem [32768];
  logic        pre_we = 1'b0;
  logic [14:0] pre_addr = '0;
  logic [11:0] pre_data = '0;
  int          xfer_cnt = 0;
  int          rd1000 = 0;
  int          rd1001 = 0;
  logic [14:0] xfer_ma_q [$];

  always #5 clk = ~clk;

  pdp8_rf08 dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .iot_i           (iot),
    .state_i         (state),
    .mb_i            (mb),
    .io_select_i     (io_select),
    .io_data_i       (io_data_in),
    .io_data_o       (io_data_out),
    .io_data_avail_o (io_data_avail),
    .io_interrupt_o  (io_interrupt),
    .io_skip_o       (io_skip),
    .ram_read_req_o  (rd),
    .ram_write_req_o (wr),
    .ram_done_i      (ram_done),
    .ram_ma_o        (ram_ma),
    .ram_out_o       (ram_out),
    .ram_in_i        (ram_in)
  );

  assign ram_in = mem[ram_ma];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (ram_done && (rd || wr)) begin
      if (wr) mem[ram_ma] <= ram_out;
      if (rd && ram_ma == 15'o01000) rd1000 <= rd1000 + 1;
      if (rd && ram_ma == 15'o01001) rd1001 <= rd1001 + 1;
      if (ram_ma != 15'o07750 && ram_ma != 15'o07751) begin
        xfer_cnt <= xfer_cnt + 1;
        xfer_ma_q.push_back(ram_ma);
      end
    end
  end

  task automatic poke(input logic [14:0] a, input logic [11:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // One IOT: state 0..3, one cycle each; outputs sampled mid-cycle in state 1.
  task automatic do_iot(input logic [11:0] instr, input logic [11:0] ac,
                        output logic skip, output logic avail, output logic [11:0] data);
    @(negedge clk);
    iot        = 1'b1;
    mb         = instr;
    io_select  = instr[8:3];
    io_data_in = ac;
    state      = 4'd0;
    @(negedge clk);
    state = 4'd1;
    #1;
    skip  = io_skip;
    avail = io_data_avail;
    data  = io_data_out;
    @(negedge clk);
    state = 4'd2;
    @(negedge clk);
    state = 4'd3;
    @(negedge clk);
    iot   = 1'b0;
    state = 4'd0;
  endtask

  task automatic wait_xfer(input int target, output bit ok);
    int n = 0;
    while (xfer_cnt < target && n < 50000) begin
      @(posedge clk);
      n++;
    end
    ok = (xfer_cnt >= target);
    repeat (12) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic s, a;
    logic [11:0] d;
    rst_n = 1'b0;
    #50;
    checks++;
    if (rd !== 1'b0 || wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_req: rd=%b wr=%b required 0 0", rd, wr);
    end
    checks++;
    if (io_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b required 0", io_interrupt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_iot(12'o6616, 12'o0000, s, a, d);
    checks++;
    if (d !== 12'o0000) begin
      errors++;
      $display("FAIL reset_dima: got %o required 0000", d);
    end
    checks++;
    if (a !== 1'b1) begin
      errors++;
      $display("FAIL reset_avail: got %b required 1", a);
    end
    checks++;
    if (rd !== 1'b0 || wr !== 1'b0 || io_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: rd=%b wr=%b irq=%b required 0 0 0", rd, wr, io_interrupt);
    end
  endtask

  task automatic test_diml();
    logic s, a;
    logic [11:0] d;
    do_iot(12'o6615, 12'o1070, s, a, d);
    do_iot(12'o6616, 12'o0000, s, a, d);
    checks++;
    if (d !== 12'o1070 || a !== 1'b1) begin
      errors++;
      $display("FAIL diml_dima: got %o avail %b required 1070 avail 1", d, a);
    end
    checks++;
    if (io_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL diml_irq: got %b required 0", io_interrupt);
    end
  endtask

  task automatic test_dmaw();
    logic s, a;
    logic [11:0] d;
    bit ok;
    int base;
    do_iot(12'o6615, 12'o0000, s, a, d);
    poke(15'o07750, 12'o7776);
    poke(15'o07751, 12'o0777);
    poke(15'o01000, 12'o1234);
    poke(15'o01001, 12'o4321);
    base = xfer_cnt;
    do_iot(12'o6605, 12'o0100, s, a, d);
    wait_xfer(base + 2, ok);
    checks++;
    if (!ok || xfer_cnt !== base + 2) begin
      errors++;
      $display("FAIL dmaw_words: got %0d required 2", xfer_cnt - base);
    end
    checks++;
    if (xfer_ma_q[base] !== 15'o01000 || xfer_ma_q[base+1] !== 15'o01001) begin
      errors++;
      $display("FAIL dmaw_addr: got %o %o required 01000 01001", xfer_ma_q[base], xfer_ma_q[base+1]);
    end
    checks++;
    if (rd1000 !== 1 || rd1001 !== 1) begin
      errors++;
      $display("FAIL dmaw_reads: got %0d %0d required 1 1", rd1000, rd1001);
    end
    checks++;
    if (mem[15'o07750] !== 12'o0000 || mem[15'o07751] !== 12'o1001) begin
      errors++;
      $display("FAIL dmaw_wc_ca: got %o %o required 0000 1001", mem[15'o07750], mem[15'o07751]);
    end
    do_iot(12'o6626, 12'o0000, s, a, d);
    checks++;
    if (d !== 12'o0102 || a !== 1'b1) begin
      errors++;
      $display("FAIL dmaw_dmac: got %o avail %b required 0102 avail 1", d, a);
    end
    do_iot(12'o6622, 12'o0000, s, a, d);
    checks++;
    if (s !== 1'b1) begin
      errors++;
      $display("FAIL dmaw_dfsc: got %b required 1", s);
    end
  endtask

  task automatic test_dmar();
    logic s, a;
    logic [11:0] d;
    bit ok;
    int base;
    do_iot(12'o6615, 12'o0070, s, a, d);
    poke(15'o07750, 12'o0000);
    poke(15'o07751, 12'o0000);
    base = xfer_cnt;
    do_iot(12'o6603, 12'o0100, s, a, d);
    wait_xfer(base + 4096, ok);
    checks++;
    if (!ok || xfer_cnt !== base + 4096) begin
      errors++;
      $display("FAIL dmar_words: got %0d required 4096", xfer_cnt - base);
    end
    checks++;
    if (xfer_ma_q[base] !== 15'o70001) begin
      errors++;
      $display("FAIL dmar_first_addr: got %o required 70001", xfer_ma_q[base]);
    end
    checks++;
    if (mem[15'o70001] !== 12'o1234 || mem[15'o70002] !== 12'o4321) begin
      errors++;
      $display("FAIL dmar_data: got %o %o required 1234 4321", mem[15'o70001], mem[15'o70002]);
    end
    checks++;
    if (mem[15'o07750] !== 12'o0000 || mem[15'o07751] !== 12'o0000) begin
      errors++;
      $display("FAIL dmar_wc_ca: got %o %o required 0000 0000", mem[15'o07750], mem[15'o07751]);
    end
    do_iot(12'o6622, 12'o0000, s, a, d);
    checks++;
    if (s !== 1'b1) begin
      errors++;
      $display("FAIL dmar_dfsc: got %b required 1", s);
    end
    do_iot(12'o6612, 12'o0000, s, a, d);
    checks++;
    if (s !== 1'b1) begin
      errors++;
      $display("FAIL dmar_dsac: got %b required 1", s);
    end
    do_iot(12'o6626, 12'o0000, s, a, d);
    checks++;
    if (d !== 12'o0100) begin
      errors++;
      $display("FAIL dmar_dmac: got %o required 0100", d);
    end
    do_iot(12'o6616, 12'o0000, s, a, d);
    checks++;
    if (d !== 12'o0070) begin
      errors++;
      $display("FAIL dmar_dima: got %o required 0070", d);
    end
  endtask

  task automatic test_ema();
    logic s, a;
    logic [11:0] d;
`ifdef RF_EMA_EN
    do_iot(12'o6645, 12'o0000, s, a, d);
    checks++;
    if (d !== 12'o0001 || a !== 1'b1) begin
      errors++;
      $display("FAIL ema_carry: got %o avail %b required 0001 avail 1", d, a);
    end
    do_iot(12'o6643, 12'o0017, s, a, d);
    do_iot(12'o6645, 12'o0000, s, a, d);
    checks++;
    if (d !== 12'o0017) begin
      errors++;
      $display("FAIL ema_dxal: got %o required 0017", d);
    end
    do_iot(12'o6641, 12'o0000, s, a, d);
    do_iot(12'o6645, 12'o0000, s, a, d);
    checks++;
    if (d !== 12'o0000) begin
      errors++;
      $display("FAIL ema_dcxa: got %o required 0000", d);
    end
`else
    do_iot(12'o6643, 12'o0017, s, a, d);
    do_iot(12'o6645, 12'o0000, s, a, d);
    checks++;
    if (d !== 12'o0000 || a !== 1'b0) begin
      errors++;
      $display("FAIL ema_absent: got %o avail %b required 0000 avail 0", d, a);
    end
`endif
  endtask

  task automatic test_busy_error();
    logic s, a;
    logic [11:0] d;
    bit ok;
    int base;
    do_iot(12'o6615, 12'o2000, s, a, d);
    poke(15'o07750, 12'o7777);
    poke(15'o07751, 12'o0000);
    ram_done = 1'b0;
    base = xfer_cnt;
    do_iot(12'o6605, 12'o0200, s, a, d);
    do_iot(12'o6603, 12'o0000, s, a, d);
    do_iot(12'o6621, 12'o0000, s, a, d);
    checks++;
    if (s !== 1'b0) begin
      errors++;
      $display("FAIL err_dfse: got %b required 0", s);
    end
    do_iot(12'o6612, 12'o0000, s, a, d);
    checks++;
    if (s !== 1'b0) begin
      errors++;
      $display("FAIL err_dsac_busy: got %b required 0", s);
    end
    do_iot(12'o6626, 12'o0000, s, a, d);
    checks++;
    if (d !== 12'o0200) begin
      errors++;
      $display("FAIL err_ignored: got %o required 0200", d);
    end
    do_iot(12'o6616, 12'o0000, s, a, d);
    checks++;
    if (d !== 12'o6004) begin
      errors++;
      $display("FAIL err_dima: got %o required 6004", d);
    end
    checks++;
    if (io_interrupt !== 1'b1 || rd !== 1'b1 || ram_ma !== 15'o07750) begin
      errors++;
      $display("FAIL err_irq_hold: irq=%b rd=%b ma=%o required 1 1 07750", io_interrupt, rd, ram_ma);
    end
    do_iot(12'o6601, 12'o0000, s, a, d);
    repeat (2) @(negedge clk);
    checks++;
    if (io_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_irq: got %b required 0", io_interrupt);
    end
    ram_done = 1'b1;
    wait_xfer(base + 1, ok);
    do_iot(12'o6612, 12'o0000, s, a, d);
    checks++;
    if (!ok || s !== 1'b1 || xfer_cnt !== base + 1) begin
      errors++;
      $display("FAIL err_finish: words %0d skip %b required 1 1", xfer_cnt - base, s);
    end
    do_iot(12'o6623, 12'o0000, s, a, d);
    checks++;
    if (s !== 1'b1 || io_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL err_disk_skip: skip %b irq %b required 1 0", s, io_interrupt);
    end
  endtask

  initial begin
    iot        = 1'b0;
    state      = 4'd0;
    mb         = '0;
    io_select  = '0;
    io_data_in = '0;
    ram_done   = 1'b1;
    test_reset();
    test_diml();
    test_dmaw();
    test_dmar();
    test_ema();
    test_busy_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
